dbg_port_arbiter: RTL and testbench
===================================

Name: dbg_port_arbiter

Overview:
- Shares the single debug-controller register port (addr/write_data/read_data/wr_en/req/ack) between two requesters: the simulation debug bridge (master 0) and the on-chip debug/JTAG front end (master 1).
- Arbitrates round-robin, holds the grant for a whole transaction, and sequences the target port protocol itself: setup cycle, command issue with req/ack, and read capture.
- Sits between the requesters and the CPU debug unit.

Parameters:
- TIMEOUT_CYCLES, 256: ack wait limit in CMD state; used only when DBG_ARB_TIMEOUT_EN is defined. Legal range 2..65535.

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  asynchronous reset, active low
- m_valid  in  2  per-master request; held high and stable until that master's m_done
- m_rnw  in  2  per-master 1 = read, 0 = write
- m_addr  in  4  per-master register address, 2 bits each (master 0 = [1:0])
- m_wdata  in  64  per-master write data, 32 bits each (master 0 = [31:0])
- m_gnt  out  2  one-hot owner of the current transaction
- m_done  out  2  one-cycle completion pulse to the owner
- m_rdata  out  32  read result; valid while m_done is high
- m_err  out  1  transaction aborted on timeout; valid while m_done is high
- addr  out  2  target register address
- write_data  out  32  target write data
- read_data  in  32  target read data, combinational from addr
- wr_en  out  1  target register write strobe
- req  out  1  target command request (address 0 writes only)
- ack  in  1  target command acknowledge

Behaviour:
- Reset: state IDLE. m_gnt=0, m_done=0, m_rdata=0, m_err=0, addr=0, write_data=0, wr_en=0, req=0. Last-grant pointer = 1, so master 0 wins the first tie.
- Reset mid-transaction drops wr_en and req immediately and asynchronously. No m_done is issued; requesters must re-present.
- States are one-hot: IDLE, SETUP, CMD, READ, DONE.
- IDLE:
  - Accepts only when some m_valid=1 and ack=0. A stale ack high blocks acceptance.
  - Winner is the valid master that is not the last grantee; if only one is valid, it wins.
  - On the accepting edge, latch rnw, addr and wdata of the winner, set m_gnt one-hot, and go to SETUP.
- SETUP (exactly 1 cycle):
  - addr and write_data come from the latched values; wr_en = ~rnw.
  - Next state: READ if rnw; CMD if write to address 0; DONE otherwise.
- CMD:
  - req = ~ack, combinational.
  - On ack=1, go to DONE.
  - addr and write_data stay stable throughout.
- READ (1 cycle): m_rdata <= read_data on the exit edge, then go to DONE.
- DONE (1 cycle):
  - m_done[owner]=1 and m_gnt is still asserted.
  - On the exit edge: last-grant pointer = owner, m_gnt cleared, go to IDLE.
- m_rdata holds its value until the next read capture. Writes leave it unchanged.
- Latency from the accepting edge to m_done high:
  - non-zero-address write: 2 cycles
  - read: 3 cycles
  - address-0 command: 3 cycles plus ack wait
- Back-to-back: a master may re-assert m_valid the cycle after m_done. With both masters continuously valid, grants alternate 0,1,0,1…
- m_valid changing for the non-owner during a transaction has no effect. A request with m_valid dropped before m_done is undefined (bench asserts against it).
- wr_en and req are never high in the same cycle.
- addr and write_data hold their last values in IDLE.

Optional Feature:
- Macro: DBG_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to CMD and increments each CMD cycle with ack=0.
  - When the count reaches TIMEOUT_CYCLES: req drops, go to DONE with m_err=1 for that cycle.
  - A late ack arriving afterwards only blocks IDLE acceptance until it falls.
- Not defined: no counter; CMD waits indefinitely; m_err is tied 0.

Test Plan:
- Reset, then master 0 writes addr=2, data=0x12345678 → wr_en high for one cycle with addr=2 and write_data=0x12345678. req never high. m_done[0] pulses 2 cycles after acceptance.
- Master 1 reads addr=1 with read_data=0xCAFEF00D → wr_en=0, req=0. m_done[1] pulses with m_rdata=0xCAFEF00D, 3 cycles after acceptance.
- Master 0 writes addr=0, data=0x00000003, target acks 5 cycles after req rises → wr_en pulses once. req is high until the ack cycle and low in that cycle. m_done[0] follows the ack, m_err=0.
- Both masters continuously issue addr=3 writes (m0 data 0xA, m1 data 0xB) from reset → grant order 0,1,0,1. write_data alternates 0xA/0xB; no cycle has two m_gnt bits set.
- Assert rst_n low while in CMD with req high → req and wr_en fall immediately, m_done stays 0, state returns to IDLE. After release, master 0 wins a simultaneous request.
- DBG_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, address-0 command with ack held low → req drops after 4 CMD cycles, m_done with m_err=1. A following request is accepted only after ack=0.

Source files
------------

// File: rtl/dbg_port_arbiter.sv
// Two-master round-robin arbiter for the debug-controller register port; sequences setup, req/ack command and read capture.
// Optional CMD ack timeout is compiled in with `define DBG_ARB_TIMEOUT_EN (TIMEOUT_CYCLES sets the limit).
module dbg_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  m_valid,
    input  logic [1:0]  m_rnw,
    input  logic [3:0]  m_addr,
    input  logic [63:0] m_wdata,
    output logic [1:0]  m_gnt,
    output logic [1:0]  m_done,
    output logic [31:0] m_rdata,
    output logic        m_err,
    output logic [1:0]  addr,
    output logic [31:0] write_data,
    input  logic [31:0] read_data,
    output logic        wr_en,
    output logic        req,
    input  logic        ack
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_SETUP = 5'b00010,
        S_CMD   = 5'b00100,
        S_READ  = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_own;
    logic        r_rnw;
    logic [1:0]  r_gnt;
    logic [1:0]  r_done;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [1:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_wr_en;

    logic        w_win;
    logic        w_win_rnw;
    logic [1:0]  w_win_addr;
    logic [31:0] w_win_wdata;
    logic [1:0]  w_own_oh;
    logic        w_tmo;

    // On a tie the master that did not own the last transaction wins.
    assign w_win       = (&m_valid) ? ~r_last : m_valid[1];
    assign w_win_rnw   = w_win ? m_rnw[1]        : m_rnw[0];
    assign w_win_addr  = w_win ? m_addr[3:2]     : m_addr[1:0];
    assign w_win_wdata = w_win ? m_wdata[63:32]  : m_wdata[31:0];
    assign w_own_oh    = {r_own, ~r_own};

`ifdef DBG_ARB_TIMEOUT_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (r_state == S_SETUP) begin
            r_cnt <= 16'd0;
        end else if (r_state == S_CMD && !ack) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Fires on the last allowed ack-low CMD cycle, so the count reaches the limit as CMD exits.
    assign w_tmo = !ack && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
    // No timeout in this build: constant 0 across the legal TIMEOUT_CYCLES range.
    assign w_tmo = (TIMEOUT_CYCLES < 2);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_own   <= 1'b0;
            r_rnw   <= 1'b0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_addr  <= 2'd0;
            r_wdata <= 32'd0;
            r_wr_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A stale ack from a timed-out command must fall before a new accept.
                    if (|m_valid && !ack) begin
                        r_own   <= w_win;
                        r_rnw   <= w_win_rnw;
                        r_addr  <= w_win_addr;
                        r_wdata <= w_win_wdata;
                        r_wr_en <= ~w_win_rnw;
                        r_gnt   <= {w_win, ~w_win};
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_wr_en <= 1'b0;
                    if (r_rnw) begin
                        r_state <= S_READ;
                    end else if (r_addr == 2'd0) begin
                        r_state <= S_CMD;
                    end else begin
                        r_done  <= w_own_oh;
                        r_state <= S_DONE;
                    end
                end
                S_CMD: begin
                    if (ack) begin
                        r_done  <= w_own_oh;
                        r_state <= S_DONE;
                    end else if (w_tmo) begin
                        r_done  <= w_own_oh;
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_READ: begin
                    r_rdata <= read_data;
                    r_done  <= w_own_oh;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 2'b00;
                    r_err   <= 1'b0;
                    r_gnt   <= 2'b00;
                    r_last  <= r_own;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req        = (r_state == S_CMD) && !ack;
    assign m_gnt      = r_gnt;
    assign m_done     = r_done;
    assign m_rdata    = r_rdata;
    assign m_err      = r_err;
    assign addr       = r_addr;
    assign write_data = r_wdata;
    assign wr_en      = r_wr_en;

endmodule

// File: tb/tb_dbg_port_arbiter.sv
// Scoreboard bench for dbg_port_arbiter: a transaction-level model predicts grant order, target writes,
// read results, error flag and latency; a negedge monitor checks every m_done and wr_en against the queues.
module tb_dbg_port_arbiter;

    localparam int TB_TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_valid;
    logic [1:0]  m_rnw;
    logic [3:0]  m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_gnt;
    logic [1:0]  m_done;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [1:0]  addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        wr_en;
    logic        req;
    logic        ack;

    dbg_port_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_rnw(m_rnw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_done(m_done), .m_rdata(m_rdata), .m_err(m_err),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .wr_en(wr_en), .req(req), .ack(ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [33:0] wq[$];
    logic [31:0] tgt_regs [4];
    logic [31:0] mregs [4];
    logic [31:0] last_rd;
    int          mlast;
    int          nchk = 0;
    int          nerr = 0;
    int          tgt_delay;
    int          tcnt;
    bit          tgt_auto;

    assign read_data = tgt_regs[addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Transaction-level reference: register file contents, last read value and round-robin pointer.
    task automatic model_txn(input int m, input logic rnw, input logic [1:0] a,
                             input logic [31:0] wd, input int d);
        exp_t e;
        e.m   = m;
        e.err = 1'b0;
        if (rnw) begin
            last_rd = mregs[a];
            e.lat   = 3;
        end else begin
            wq.push_back({a, wd});
            mregs[a] = wd;
            e.lat    = (a == 2'd0) ? 3 + d : 2;
`ifdef DBG_ARB_TIMEOUT_EN
            if (a == 2'd0 && d >= TB_TMO) begin
                e.lat = 2 + TB_TMO;
                e.err = 1'b1;
            end
`endif
        end
        e.rd = last_rd;
        exp_q.push_back(e);
        mlast = m;
    endtask

    task automatic wait_done(input logic [1:0] pend_in);
        logic [1:0] pend;
        int n;
        pend = pend_in;
        n = 0;
        while (pend != 2'b00 && n < 400) begin
            @(posedge clk); #2;
            n++;
            for (int i = 0; i < 2; i++) begin
                if (pend[i] && m_done[i]) begin
                    pend[i]    = 1'b0;
                    m_valid[i] = 1'b0;
                end
            end
        end
        chk("done_within_budget", {62'd0, pend}, 64'd0);
        m_valid = m_valid & ~pend;
    endtask

    task automatic run_round(input logic [1:0] mask, input logic [1:0] rnw,
                             input logic [3:0] a, input logic [63:0] wd, input int d);
        int first;
        if (mask == 2'b11) first = (mlast == 0) ? 1 : 0;
        else               first = mask[1] ? 1 : 0;
        model_txn(first, rnw[first], a[2*first +: 2], wd[32*first +: 32], d);
        if (mask == 2'b11)
            model_txn(1 - first, rnw[1-first], a[2*(1-first) +: 2], wd[32*(1-first) +: 32], d);
        tgt_delay = d;
        m_rnw     = rnw;
        m_addr    = a;
        m_wdata   = wd;
        m_valid   = mask;
        wait_done(mask);
    endtask

    // Both masters hold m_valid across n transactions each.
    task automatic run_cont(input int n);
        int cur;
        int cnt [2];
        int k;
        cur = (mlast == 0) ? 1 : 0;
        for (int j = 0; j < 2 * n; j++) begin
            model_txn(cur, 1'b0, 2'd3, (cur == 1) ? 32'hB : 32'hA, 0);
            cur = 1 - cur;
        end
        cnt[0] = 0; cnt[1] = 0; k = 0;
        m_rnw = 2'b00; m_addr = 4'b1111; m_wdata = {32'hB, 32'hA}; m_valid = 2'b11;
        while ((cnt[0] < n || cnt[1] < n) && k < 400) begin
            @(posedge clk); #2;
            k++;
            for (int i = 0; i < 2; i++) begin
                if (m_done[i]) begin
                    cnt[i]++;
                    if (cnt[i] == n) m_valid[i] = 1'b0;
                end
            end
        end
        chk("cont_within_budget", {63'd0, (k < 400)}, 64'd1);
        m_valid = 2'b00;
    endtask

    // Target: register file written on wr_en, ack a configurable number of cycles after req rises.
    initial begin
        tcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (wr_en) tgt_regs[addr] = write_data;
            if (!rst_n) begin
                tcnt = 0;
                if (tgt_auto) ack = 1'b0;
            end else if (tgt_auto) begin
                if (ack) begin
                    ack  = 1'b0;
                    tcnt = 0;
                end else if (req) begin
                    if (tcnt >= tgt_delay) ack = 1'b1;
                    else tcnt++;
                end else begin
                    tcnt = 0;
                end
            end
        end
    end

    int          cyc = 0;
    int          acc_cyc = 0;
    logic [1:0]  prev_gnt = 2'b00;
    exp_t        mon_e;
    logic [33:0] mon_w;
    logic [1:0]  mon_oh;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("gnt_onehot", {63'd0, ($countones(m_gnt) <= 1)}, 64'd1);
            if (m_gnt != 2'b00 && prev_gnt == 2'b00) acc_cyc = cyc - 1;
            if (m_gnt != 2'b00 && m_done == 2'b00)
                chk("owner_valid_held", {63'd0, |(m_gnt & m_valid)}, 64'd1);
            if (m_done != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {62'd0, m_done}, 64'd0);
                end else begin
                    mon_e  = exp_q.pop_front();
                    mon_oh = (mon_e.m == 1) ? 2'b10 : 2'b01;
                    chk("done_owner", {62'd0, m_done}, {62'd0, mon_oh});
                    chk("gnt_at_done", {62'd0, m_gnt}, {62'd0, mon_oh});
                    chk("rdata", {32'd0, m_rdata}, {32'd0, mon_e.rd});
                    chk("err", {63'd0, m_err}, {63'd0, mon_e.err});
                    chk("latency", 64'(cyc - acc_cyc), 64'(mon_e.lat));
                end
            end
            if (wr_en) begin
                chk("wr_req_excl", {63'd0, req}, 64'd0);
                if (wq.size() == 0) begin
                    chk("unexpected_wr_en", {63'd0, wr_en}, 64'd0);
                end else begin
                    mon_w = wq.pop_front();
                    chk("wr_addr", {62'd0, addr}, {62'd0, mon_w[33:32]});
                    chk("wr_data", {32'd0, write_data}, {32'd0, mon_w[31:0]});
                end
            end
            if (req) chk("req_addr0", {62'd0, addr}, 64'd0);
        end
        prev_gnt = m_gnt;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0]  r_mask;
        logic [1:0]  r_rnw;
        logic [3:0]  r_a;
        logic [63:0] r_wd;
        rst_n = 1'b0; m_valid = 2'b00; m_rnw = 2'b00; m_addr = 4'd0; m_wdata = 64'd0;
        ack = 1'b0; tgt_auto = 1'b1; tgt_delay = 0;
        for (int i = 0; i < 4; i++) begin
            tgt_regs[i] = $urandom;
            mregs[i]    = tgt_regs[i];
        end
        tgt_regs[1] = 32'hCAFEF00D;
        mregs[1]    = 32'hCAFEF00D;
        mlast   = 1;
        last_rd = 32'd0;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_gnt", {62'd0, m_gnt}, 64'd0);
        chk("rst_done", {62'd0, m_done}, 64'd0);
        chk("rst_rdata", {32'd0, m_rdata}, 64'd0);
        chk("rst_err", {63'd0, m_err}, 64'd0);
        chk("rst_addr", {62'd0, addr}, 64'd0);
        chk("rst_wdata", {32'd0, write_data}, 64'd0);
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_req", {63'd0, req}, 64'd0);
        rst_n = 1'b1;

        run_cont(4);
        run_round(2'b01, 2'b00, 4'b0010, {32'd0, 32'h12345678}, 0);
        run_round(2'b10, 2'b10, 4'b0100, 64'd0, 0);
        run_round(2'b01, 2'b00, 4'b0000, {32'd0, 32'h00000003}, 5);

        for (int r = 0; r < 40; r++) begin
            r_mask = 2'($urandom_range(1, 3));
            r_rnw  = 2'($urandom);
            r_a    = 4'($urandom);
            r_wd   = {$urandom, $urandom};
            run_round(r_mask, r_rnw, r_a, r_wd, $urandom_range(0, 6));
        end

        // Reset while the command is outstanding: no completion, pointer back to master 1.
        tgt_delay = 50;
        wq.push_back({2'b00, 32'h5A5A0001});
        mregs[0] = 32'h5A5A0001;
        m_rnw = 2'b00; m_addr = 4'd0; m_wdata = {32'd0, 32'h5A5A0001}; m_valid = 2'b01;
        n = 0;
        while (!req && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("req_seen_before_reset", {63'd0, req}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", {63'd0, req}, 64'd0);
        chk("rst_mid_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_mid_done", {62'd0, m_done}, 64'd0);
        chk("rst_mid_gnt", {62'd0, m_gnt}, 64'd0);
        m_valid = 2'b00;
        mlast   = 1;
        last_rd = 32'd0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        run_round(2'b11, 2'b00, 4'b1111, {32'h000000B1, 32'h000000A1}, 0);

`ifdef DBG_ARB_TIMEOUT_EN
        tgt_auto = 1'b0;
        ack = 1'b0;
        run_round(2'b01, 2'b00, 4'b0000, {32'd0, 32'h00000077}, 100);
        ack = 1'b1;
        model_txn(1, 1'b0, 2'd2, 32'h00000055, 0);
        m_rnw = 2'b00; m_addr = 4'b1000; m_wdata = {32'h00000055, 32'd0}; m_valid = 2'b10;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #2;
            chk("stale_ack_blocks", {62'd0, m_gnt}, 64'd0);
        end
        ack = 1'b0;
        wait_done(2'b10);
        tgt_auto = 1'b1;
`endif

        repeat (5) @(posedge clk);
        #2;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("wq_drained", 64'(wq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
